button_reader: RTL and testbench

Debounced push-button input block: the input-side counterpart of the board's LED driver logic. It synchronises a raw mechanical button pin into the CLK domain and filters contact bounce. It then emits one-cycle event pulses for press, release, short click and long hold, plus a running press counter. It sits between the board pin and any control logic that reacts to user input, such as mode selection or blink-rate changes.

---
 rtl/button_reader.sv | 151 +++++++++++++++
 tb/tb_button_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// Debounced push-button reader: 2-flop sync, stable-count debounce, press/release/short/long pulses.
// Level/pulses valid DEBOUNCE_CYCLES+2 edges after a pin change; no backpressure, pulses are fire-and-forget.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LONG_CYCLES     = 27_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_in,
  output logic       o_btn_level,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic       o_short_pulse,
  output logic       o_long_pulse,
  output logic [7:0] o_press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic [7:0]    r_press_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_press_pulse;
  logic          r_release_pulse;
  logic          r_short_pulse;
  logic          r_long_pulse;
  logic          w_press;
  logic          w_release;
  logic          w_short;
  logic          w_long;
  logic          w_pressed;
  logic          w_accept;
  logic          w_rise;
  logic          w_fall;

  // Sync flops idle at the released pin level so a button held through reset is seen as a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;
  assign w_accept  = (w_pressed != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise    = w_accept && !r_level;
  assign w_fall    = w_accept && r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_pressed == r_level) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_level  <= ~r_level;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= '0;
      r_press_count   <= 8'd0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_pulse   <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_press_pulse   <= w_press;
      r_release_pulse <= w_release;
      r_short_pulse   <= w_short;
      r_long_pulse    <= w_long;
      if (w_press) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  // A release on the same edge as the long threshold is treated as a short click.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESSED;
          w_hold_nxt  = '0;
          w_press     = 1'b1;
        end
      end
      S_PRESSED: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
          w_short     = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = S_LONG_HELD;
          w_long      = 1'b1;
        end else begin
          w_hold_nxt  = r_hold_cnt + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_btn_level     = r_level;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_short_pulse   = r_short_pulse;
  assign o_long_pulse    = r_long_pulse;
  assign o_press_count   = r_press_count;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low pin.
module tb_button_reader;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       lvl;
  logic       pp;
  logic       rp;
  logic       sp;
  logic       lp;
  logic [7:0] cnt;

  int n_cmp;
  int n_err;
  int n_press;
  int n_rel;
  int n_short;
  int n_long;
  int n_lvl;
  int s_press;
  int s_rel;
  int s_short;
  int s_long;
  int s_lvl;

  button_reader #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_btn_in       (btn),
    .o_btn_level    (lvl),
    .o_press_pulse  (pp),
    .o_release_pulse(rp),
    .o_short_pulse  (sp),
    .o_long_pulse   (lp),
    .o_press_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge and tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pp)  n_press++;
    if (rp)  n_rel++;
    if (sp)  n_short++;
    if (lp)  n_long++;
    if (lvl) n_lvl++;
  endtask

  task automatic snap();
    s_press = n_press;
    s_rel   = n_rel;
    s_short = n_short;
    s_long  = n_long;
    s_lvl   = n_lvl;
  endtask

  task automatic press_release();
    btn = 1'b0;
    repeat (6) tick();
    btn = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_lvl = 0;
    rst_n = 1'b0;
    btn   = 1'b1;

    // Reset state, then idle released pin
    repeat (3) tick();
    chk("rst_level", lvl, 0);
    chk("rst_pulses", {pp, rp, sp, lp}, 0);
    chk("rst_count", cnt, 0);
    snap();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("idle_press_n", n_press - s_press, 0);
    chk("idle_rel_n", n_rel - s_rel, 0);
    chk("idle_level_n", n_lvl - s_lvl, 0);
    chk("idle_count", cnt, 0);

    // Press latency: high after edge k+5
    btn = 1'b0;
    repeat (5) tick();
    chk("press_early_level", lvl, 0);
    chk("press_early_pulse", pp, 0);
    tick();
    chk("press_level", lvl, 1);
    chk("press_pulse", pp, 1);
    chk("press_count1", cnt, 1);
    snap();

    // Short click: pin released right after PRESS_PULSE, release accepted 6 cycles later
    btn = 1'b1;
    tick();
    chk("press_pulse_width", pp, 0);
    repeat (4) tick();
    chk("short_early_level", lvl, 1);
    chk("short_early_rel", rp, 0);
    tick();
    chk("short_level", lvl, 0);
    chk("short_rel", rp, 1);
    chk("short_short", sp, 1);
    tick();
    chk("short_rel_width", {rp, sp}, 0);
    chk("short_no_long", n_long - s_long, 0);

    // Bounce: runs of 3 and 2 low cycles never reach 4 stable cycles
    snap();
    for (int r = 0; r < 5; r++) begin
      btn = 1'b0; repeat (3) tick();
      btn = 1'b1; tick();
      btn = 1'b0; repeat (2) tick();
      btn = 1'b1; tick();
    end
    repeat (10) tick();
    chk("bounce_level_n", n_lvl - s_lvl, 0);
    chk("bounce_press_n", n_press - s_press, 0);
    chk("bounce_rel_n", n_rel - s_rel, 0);
    chk("bounce_count", cnt, 1);

    // Long hold of 30 cycles
    btn = 1'b0;
    repeat (6) tick();
    chk("long_press_pulse", pp, 1);
    chk("long_count2", cnt, 2);
    snap();
    repeat (9) tick();
    chk("long_early", lp, 0);
    tick();
    chk("long_pulse_at10", lp, 1);
    tick();
    chk("long_pulse_width", lp, 0);
    repeat (19) tick();
    btn = 1'b1;
    repeat (5) tick();
    chk("long_rel_early_level", lvl, 1);
    tick();
    chk("long_rel", rp, 1);
    chk("long_rel_no_short", sp, 0);
    chk("long_once", n_long - s_long, 1);
    repeat (3) tick();

    // Release accepted on the same edge as the long threshold
    btn = 1'b0;
    repeat (6) tick();
    chk("tie_press_pulse", pp, 1);
    chk("tie_count3", cnt, 3);
    snap();
    repeat (4) tick();
    btn = 1'b1;
    repeat (6) tick();
    chk("tie_rel", rp, 1);
    chk("tie_short", sp, 1);
    chk("tie_no_long", lp, 0);
    chk("tie_long_n", n_long - s_long, 0);
    repeat (3) tick();

    // Count wrap: 252 more presses reach 255, the next shows 0
    snap();
    for (int i = 0; i < 252; i++) press_release();
    chk("wrap_count255", cnt, 255);
    btn = 1'b0;
    repeat (6) tick();
    chk("wrap_pulse", pp, 1);
    chk("wrap_count0", cnt, 0);
    chk("wrap_press_n", n_press - s_press, 253);

    // Reset mid-press with button held through reset
    repeat (2) tick();
    snap();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_level", lvl, 0);
    chk("mid_rst_pulses", {pp, rp, sp, lp}, 0);
    chk("mid_rst_count", cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rearm_early_level", lvl, 0);
    chk("rearm_no_release", n_rel - s_rel, 0);
    tick();
    chk("rearm_level", lvl, 1);
    chk("rearm_pulse", pp, 1);
    chk("rearm_count", cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
